// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment digit driver.
// Holds the active-low segment patterns, the all-off output levels and the
// scan FSM state encoding.
// Segment bit order is g..a: bit 6 = g, bit 0 = a. A 0 bit lights a segment.
package ss_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

endpackage

// File: rtl/ss_hex_decoder.sv
// Combinational hex-to-seven-segment decoder.
// Ports:
//   nibble  in  4  hex digit 0..F
//   pattern out 7  active-low segment pattern, bit order g..a
module ss_hex_decoder
    import ss_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        unique case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            4'hF: pattern = SEG_F;
        endcase
    end

endmodule

// File: rtl/ss_digit_driver.sv
// Seven-segment digit driver: consumes the scan counter's digit select and
// drives 8 common anodes, 7 segments and the decimal point (all active-low).
// A double-buffered display value is swapped only at the 7->0 wrap, each
// select change inserts an all-off blanking interval, and optional
// leading-zero suppression dims high-order zero digits.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   sel         digit select, 0 = rightmost
//   value       eight hex nibbles, nibble k on digit k
//   dp_in       decimal point request per digit
//   dig_en      per-digit enable
//   zs_en       leading-zero suppression enable (live)
//   load        strobe capturing value/dp_in/dig_en into the pending buffer
//   an, seg, dp active-low outputs
//   frame_tick  one-cycle pulse when the active buffer updates
module ss_digit_driver
    import ss_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 200,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  dig_en,
    input  logic        zs_en,
    input  logic        load,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    state_t state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]  sel_q;

    logic [31:0] pend_value, pend_value_d, act_value, act_value_d;
    logic [7:0]  pend_dp, pend_dp_d, act_dp, act_dp_d;
    logic [7:0]  pend_en, pend_en_d, act_en, act_en_d;
    logic        pend_valid, pend_valid_d;
    logic        tick_d;

    logic        change, wrap, show, suppressed, lit;
    logic [3:0]  nibble;
    logic [6:0]  pattern;
    logic [7:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    assign change = (sel != sel_q);
    assign wrap   = (sel_q == 3'd7) && (sel == 3'd0);

    // Double buffer: a load coincident with the wrap bypasses pending.
    always_comb begin
        pend_value_d = pend_value;
        pend_dp_d    = pend_dp;
        pend_en_d    = pend_en;
        pend_valid_d = pend_valid;
        act_value_d  = act_value;
        act_dp_d     = act_dp;
        act_en_d     = act_en;
        tick_d       = 1'b0;
        if (wrap && load) begin
            act_value_d  = value;
            act_dp_d     = dp_in;
            act_en_d     = dig_en;
            pend_valid_d = 1'b0;
            tick_d       = 1'b1;
        end else if (wrap && pend_valid) begin
            act_value_d  = pend_value;
            act_dp_d     = pend_dp;
            act_en_d     = pend_en;
            pend_valid_d = 1'b0;
            tick_d       = 1'b1;
        end else if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp_in;
            pend_en_d    = dig_en;
            pend_valid_d = 1'b1;
        end
    end

    // Digit content is taken from sel (equal to sel_q except on a change
    // with no blanking) and from the post-swap buffer, so the first digit of
    // a new frame already shows the new value.
    always_comb begin
        nibble = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (sel == 3'(k)) nibble = act_value_d[4*k +: 4];
        end
    end

    assign suppressed = zs_en && (sel != 3'd0) && ((act_value_d >> {sel, 2'b00}) == '0);
    assign lit        = act_en_d[sel] && !suppressed;

    ss_hex_decoder u_dec (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // Next state and registered-output values.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        show    = 1'b0;
        if (change) begin
            if (BLANK_CYCLES == 0) begin
                state_d = ST_SHOW;
                show    = 1'b1;
            end else begin
                state_d = ST_BLANK;
                cnt_d   = CNT_W'(BLANK_CYCLES);
            end
        end else begin
            unique case (state)
                ST_SHOW: show = 1'b1;
                ST_BLANK: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        show    = 1'b1;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
            endcase
        end

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (show && lit) begin
            an_d  = ~(8'b1 << sel);
            seg_d = pattern;
            dp_d  = ~act_dp_d[sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SHOW;
            cnt   <= '0;
            sel_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sel_q <= sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            frame_tick <= 1'b0;
        end else begin
            pend_value <= pend_value_d;
            pend_dp    <= pend_dp_d;
            pend_en    <= pend_en_d;
            pend_valid <= pend_valid_d;
            act_value  <= act_value_d;
            act_dp     <= act_dp_d;
            act_en     <= act_en_d;
            frame_tick <= tick_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
